am2942_dma_seq: RTL and testbench

- Transfer sequencer that sits directly upstream of the am2942 DMA address/word-count generator.
- Programs the am2942 control, address and word-count registers.
- Arbitrates for the system bus and handshakes with a requesting device and with memory.
- Pulses the am2942 count enables once per completed transfer, and stops on the am2942 DONE output.
- Raises an interrupt when the block completes or times out.

---
 rtl/am2942_dma_seq_if.sv | 45 ++++
 rtl/am2942_dma_seq.sv | 205 ++++++++++++++++++++
 tb/tb_am2942_dma_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/am2942_dma_seq_if.sv
// Bus bundle between the transfer sequencer and its surroundings
// (control inputs, device/bus/memory handshakes, am2942 control outputs).
//   master : the sequencer side (drives am2942 controls and handshakes)
//   slave  : the environment side (drives requests, grants, DONE/ACO)
interface am2942_dma_seq_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic             abort;
   logic [2:0]       mode;
   logic [WIDTH-1:0] addr;
   logic [WIDTH-1:0] count;
   logic             dreq;
   logic             bgnt;
   logic             brdy;
   logic             done;
   logic             aco_;

   logic [3:0]       i;
   logic             ien_;
   logic [WIDTH-1:0] dout;
   logic             dout_oe;
   logic             aci_;
   logic             wci_;
   logic             oed_;
   logic             breq;
   logic             dack;
   logic             strobe;
   logic             busy;
   logic             irq;
   logic             err;
   logic             wrap;

   modport master (
      input  start, abort, mode, addr, count, dreq, bgnt, brdy, done, aco_,
      output i, ien_, dout, dout_oe, aci_, wci_, oed_, breq, dack, strobe,
             busy, irq, err, wrap
   );

   modport slave (
      output start, abort, mode, addr, count, dreq, bgnt, brdy, done, aco_,
      input  i, ien_, dout, dout_oe, aci_, wci_, oed_, breq, dack, strobe,
             busy, irq, err, wrap
   );
endinterface

// File: rtl/am2942_dma_seq.sv
// Transfer sequencer upstream of an am2942 DMA address/word-count generator.
// Programs the am2942 control/address/word-count registers, arbitrates for the
// bus, handshakes with device and memory, pulses the count enables once per
// completed transfer and stops on DONE or on a memory-ready timeout.
// Ports:
//   cp   : clock, rising edge
//   mr_  : asynchronous active-low master reset
//   bus  : am2942_dma_seq_if.master (requests, handshakes, am2942 controls,
//          busy/irq/err/wrap status)
module am2942_dma_seq #(
   parameter int unsigned WIDTH   = 8,
   parameter bit          BURST   = 1'b1,
   parameter int unsigned WAITMAX = 15
) (
   input logic              cp,
   input logic              mr_,
   am2942_dma_seq_if.master bus
);
   localparam int unsigned       WAIT_W    = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAITMAX - 1);
   localparam logic [3:0]        I_WRCR    = 4'b0000;
   localparam logic [3:0]        I_LDAR    = 4'b0101;
   localparam logic [3:0]        I_LDWC    = 4'b0110;
   localparam logic [3:0]        I_ENCT    = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE, S_WRCR, S_LDAR, S_LDWC, S_ARB, S_XFER, S_FIN
   } state_e;

   state_e             state_q, state_d;
   logic [2:0]         mode_q, mode_d;
   logic [WIDTH-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               hold_q, hold_d;
   logic               irq_q, irq_d;
   logic               err_q, err_d;
   logic               wrap_q, wrap_d;

   logic [3:0]         i_c;
   logic               ien_c;
   logic [WIDTH-1:0]   dout_c;
   logic               dout_oe_c;
   logic               pulse_c;
   logic               oed_c;
   logic               breq_c;
   logic               dack_c;
   logic               strobe_c;
   logic               busy_c;

   // State and latched operands
   always_ff @(posedge cp or negedge mr_) begin
      if (!mr_) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         addr_q  <= '0;
         count_q <= '0;
         wait_q  <= '0;
         hold_q  <= 1'b0;
         irq_q   <= 1'b0;
         err_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         irq_q   <= irq_d;
         err_q   <= err_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next state and per-state am2942/handshake controls
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      addr_d    = addr_q;
      count_d   = count_q;
      wait_d    = wait_q;
      hold_d    = 1'b0;
      irq_d     = irq_q;
      err_d     = err_q;
      wrap_d    = wrap_q;

      i_c       = I_ENCT;
      ien_c     = 1'b1;
      dout_c    = '0;
      dout_oe_c = 1'b0;
      pulse_c   = 1'b0;
      oed_c     = 1'b1;
      breq_c    = 1'b0;
      dack_c    = 1'b0;
      strobe_c  = 1'b0;
      busy_c    = 1'b0;

      case (state_q)
         S_IDLE, S_FIN: begin
            if (bus.start) begin
               mode_d  = bus.mode;
               addr_d  = bus.addr;
               count_d = bus.count;
               irq_d   = 1'b0;
               err_d   = 1'b0;
               wrap_d  = 1'b0;
               state_d = S_WRCR;
            end
         end
         S_WRCR: begin
            i_c       = I_WRCR;
            ien_c     = 1'b0;
            dout_c    = WIDTH'(mode_q);
            dout_oe_c = 1'b1;
            busy_c    = 1'b1;
            state_d   = S_LDAR;
         end
         S_LDAR: begin
            i_c       = I_LDAR;
            ien_c     = 1'b0;
            dout_c    = addr_q;
            dout_oe_c = 1'b1;
            busy_c    = 1'b1;
            state_d   = S_LDWC;
         end
         S_LDWC: begin
            i_c       = I_LDWC;
            ien_c     = 1'b0;
            dout_c    = count_q;
            dout_oe_c = 1'b1;
            busy_c    = 1'b1;
            state_d   = S_ARB;
         end
         S_ARB: begin
            ien_c  = 1'b0;
            busy_c = 1'b1;
            // hold_q keeps the request down for one cycle after a transfer
            breq_c = bus.dreq & ~hold_q;
            if (breq_c && bus.bgnt) begin
               wait_d  = '0;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            ien_c    = 1'b0;
            busy_c   = 1'b1;
            breq_c   = 1'b1;
            dack_c   = 1'b1;
            strobe_c = 1'b1;
            oed_c    = 1'b0;
            if (bus.brdy) begin
               // am2942 advances on this same edge
               pulse_c = 1'b1;
               if (!bus.aco_) wrap_d = 1'b1;
               if (bus.done) begin
                  irq_d   = 1'b1;
                  state_d = S_FIN;
               end else if (BURST && bus.dreq) begin
                  wait_d = '0;
               end else begin
                  hold_d  = 1'b1;
                  state_d = S_ARB;
               end
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               irq_d   = 1'b1;
               state_d = S_FIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything: no count pulse, no status or operand update
      if (bus.abort) begin
         state_d = S_IDLE;
         pulse_c = 1'b0;
         hold_d  = 1'b0;
         mode_d  = mode_q;
         addr_d  = addr_q;
         count_d = count_q;
         wait_d  = wait_q;
         irq_d   = irq_q;
         err_d   = err_q;
         wrap_d  = wrap_q;
      end
   end

   assign bus.i       = i_c;
   assign bus.ien_    = ien_c;
   assign bus.dout    = dout_c;
   assign bus.dout_oe = dout_oe_c;
   assign bus.aci_    = ~pulse_c;
   assign bus.wci_    = ~pulse_c;
   assign bus.oed_    = oed_c;
   assign bus.breq    = breq_c;
   assign bus.dack    = dack_c;
   assign bus.strobe  = strobe_c;
   assign bus.busy    = busy_c;
   assign bus.irq     = irq_q;
   assign bus.err     = err_q;
   assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_am2942_dma_seq.sv
// Bench for am2942_dma_seq: two instances (lane 0 BURST=1, lane 1 BURST=0,
// both WAITMAX=4) share stimulus; each has its own small am2942 counter model
// supplying DONE/ACO and a behavioural reference checked every cycle.
module tb_am2942_dma_seq;
   localparam int unsigned WMAX = 4;

   typedef struct packed {
      logic [3:0] i;
      logic       ien_;
      logic [7:0] dout;
      logic       dout_oe;
      logic       aci_;
      logic       wci_;
      logic       oed_;
      logic       breq;
      logic       dack;
      logic       strobe;
      logic       busy;
      logic       irq;
      logic       err;
      logic       wrap;
   } outs_t;

   localparam outs_t RST_V = {4'b0111, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0};

   localparam int P_IDLE = 0, P_CR = 1, P_AR = 2, P_WC = 3, P_ARB = 4, P_XF = 5, P_FIN = 6;

   logic       cp = 1'b0;
   logic       mr_n = 1'b0;
   logic       start_r = 1'b0, abort_r = 1'b0, dreq_r = 1'b0, bgnt_r = 1'b0, brdy_r = 1'b0;
   logic [2:0] mode_r = 3'd0;
   logic [7:0] addr_r = 8'd0, count_r = 8'd0;

   int n_checks = 0;
   int n_fail   = 0;

   am2942_dma_seq_if #(.WIDTH(8)) bus0 ();
   am2942_dma_seq_if #(.WIDTH(8)) bus1 ();

   am2942_dma_seq #(.WIDTH(8), .BURST(1'b1), .WAITMAX(WMAX)) u_dut_b1 (
      .cp(cp), .mr_(mr_n), .bus(bus0));
   am2942_dma_seq #(.WIDTH(8), .BURST(1'b0), .WAITMAX(WMAX)) u_dut_b0 (
      .cp(cp), .mr_(mr_n), .bus(bus1));

   always #5 cp = ~cp;

   // am2942 stand-in: control, address and word-count registers
   logic [2:0] env_cr [2] = '{3'd0, 3'd0};
   logic [7:0] env_ar [2] = '{8'd0, 8'd0};
   logic [7:0] env_wc [2] = '{8'd0, 8'd0};
   logic       env_done [2];
   logic       env_aco [2];
   outs_t      act [2];

   assign act[0] = {bus0.i, bus0.ien_, bus0.dout, bus0.dout_oe, bus0.aci_, bus0.wci_, bus0.oed_,
                    bus0.breq, bus0.dack, bus0.strobe, bus0.busy, bus0.irq, bus0.err, bus0.wrap};
   assign act[1] = {bus1.i, bus1.ien_, bus1.dout, bus1.dout_oe, bus1.aci_, bus1.wci_, bus1.oed_,
                    bus1.breq, bus1.dack, bus1.strobe, bus1.busy, bus1.irq, bus1.err, bus1.wrap};

   assign bus0.start = start_r;  assign bus1.start = start_r;
   assign bus0.abort = abort_r;  assign bus1.abort = abort_r;
   assign bus0.mode  = mode_r;   assign bus1.mode  = mode_r;
   assign bus0.addr  = addr_r;   assign bus1.addr  = addr_r;
   assign bus0.count = count_r;  assign bus1.count = count_r;
   assign bus0.dreq  = dreq_r;   assign bus1.dreq  = dreq_r;
   assign bus0.bgnt  = bgnt_r;   assign bus1.bgnt  = bgnt_r;
   assign bus0.brdy  = brdy_r;   assign bus1.brdy  = brdy_r;
   assign bus0.done  = env_done[0];
   assign bus1.done  = env_done[1];
   assign bus0.aco_  = env_aco[0];
   assign bus1.aco_  = env_aco[1];

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         env_done[k] = (env_wc[k] == 8'd1);
         env_aco[k]  = env_cr[k][2] ? (env_ar[k] != 8'h00) : (env_ar[k] != 8'hFF);
      end
   end

   always @(posedge cp) begin
      for (int k = 0; k < 2; k++) begin
         if (!act[k].ien_) begin
            if (act[k].i == 4'b0000) env_cr[k] <= act[k].dout[2:0];
            if (act[k].i == 4'b0101) env_ar[k] <= act[k].dout;
            if (act[k].i == 4'b0110) env_wc[k] <= act[k].dout;
         end
         if (!act[k].aci_) env_ar[k] <= env_cr[k][2] ? env_ar[k] - 8'd1 : env_ar[k] + 8'd1;
         if (!act[k].wci_) env_wc[k] <= env_wc[k] - 8'd1;
      end
   end

   // Reference: phase of the block transfer plus sticky flags, per lane
   int         ph [2];
   int         m_wait [2];
   logic [2:0] m_mode [2];
   logic [7:0] m_addr [2], m_count [2];
   bit         m_hold [2], m_irq [2], m_err [2], m_wrap [2];
   int         aci_cnt [2], rise_cnt [2];
   bit         prev_breq [2];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   task automatic model_reset(input int k);
      ph[k] = P_IDLE; m_wait[k] = 0; m_mode[k] = 3'd0; m_addr[k] = 8'd0; m_count[k] = 8'd0;
      m_hold[k] = 1'b0; m_irq[k] = 1'b0; m_err[k] = 1'b0; m_wrap[k] = 1'b0;
   endtask

   // What the coming clock edge does, given the inputs now applied
   task automatic model_next(input int k);
      if (!mr_n) begin
         model_reset(k);
         return;
      end
      if (abort_r) begin
         ph[k] = P_IDLE;
         m_hold[k] = 1'b0;
         return;
      end
      case (ph[k])
         P_IDLE, P_FIN: if (start_r) begin
            m_mode[k] = mode_r; m_addr[k] = addr_r; m_count[k] = count_r;
            m_irq[k] = 1'b0; m_err[k] = 1'b0; m_wrap[k] = 1'b0;
            ph[k] = P_CR;
         end
         P_CR: ph[k] = P_AR;
         P_AR: ph[k] = P_WC;
         P_WC: ph[k] = P_ARB;
         P_ARB: begin
            if (dreq_r && !m_hold[k] && bgnt_r) begin
               ph[k] = P_XF;
               m_wait[k] = 0;
            end
            m_hold[k] = 1'b0;
         end
         P_XF: begin
            if (brdy_r) begin
               if (!env_aco[k]) m_wrap[k] = 1'b1;
               if (env_done[k]) begin
                  ph[k] = P_FIN;
                  m_irq[k] = 1'b1;
               end else if (k == 0 && dreq_r) begin
                  m_wait[k] = 0;
               end else begin
                  ph[k] = P_ARB;
                  m_hold[k] = 1'b1;
               end
            end else begin
               m_wait[k]++;
               if (m_wait[k] == int'(WMAX)) begin
                  m_err[k] = 1'b1;
                  m_irq[k] = 1'b1;
                  ph[k] = P_FIN;
               end
            end
         end
         default: ph[k] = P_IDLE;
      endcase
   endtask

   function automatic outs_t expect_out(input int k);
      outs_t e;
      e = RST_V;
      e.irq = m_irq[k];
      e.err = m_err[k];
      e.wrap = m_wrap[k];
      case (ph[k])
         P_CR:  begin e.i = 4'b0000; e.ien_ = 1'b0; e.dout = {5'b0, m_mode[k]}; e.dout_oe = 1'b1; e.busy = 1'b1; end
         P_AR:  begin e.i = 4'b0101; e.ien_ = 1'b0; e.dout = m_addr[k]; e.dout_oe = 1'b1; e.busy = 1'b1; end
         P_WC:  begin e.i = 4'b0110; e.ien_ = 1'b0; e.dout = m_count[k]; e.dout_oe = 1'b1; e.busy = 1'b1; end
         P_ARB: begin e.ien_ = 1'b0; e.busy = 1'b1; e.breq = dreq_r && !m_hold[k]; end
         P_XF:  begin
            e.ien_ = 1'b0; e.busy = 1'b1; e.breq = 1'b1; e.dack = 1'b1; e.strobe = 1'b1; e.oed_ = 1'b0;
            e.aci_ = !(brdy_r && !abort_r);
            e.wci_ = e.aci_;
         end
         default: ;
      endcase
      return e;
   endfunction

   // One clock: count pulses, advance the model, then compare after the edge
   task automatic tick();
      #1;
      for (int k = 0; k < 2; k++) begin
         if (act[k].aci_ == 1'b0) aci_cnt[k]++;
         model_next(k);
      end
      @(posedge cp);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("outs_lane%0d", k), 32'(act[k]), 32'(expect_out(k)));
         if (act[k].breq && !prev_breq[k]) rise_cnt[k]++;
         prev_breq[k] = act[k].breq;
      end
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 2; k++) begin
         aci_cnt[k] = 0;
         rise_cnt[k] = 0;
      end
   endtask

   task automatic kick(input logic [7:0] a, input logic [7:0] c, input logic b);
      mode_r = 3'd0; addr_r = a; count_r = c; dreq_r = 1'b1; bgnt_r = 1'b1; brdy_r = b;
      start_r = 1'b1;
      clear_counts();
   endtask

   initial begin
      logic [7:0] exp_ar [3];
      logic [7:0] prev_ar;
      int         np;
      bit         saw_ff, saw_00;
      exp_ar = '{8'h09, 8'h0A, 8'h0B};
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         prev_breq[k] = 1'b0;
      end
      clear_counts();

      #12;
      check("reset_lane0", 32'(act[0]), 32'(RST_V));
      check("reset_lane1", 32'(act[1]), 32'(RST_V));
      mr_n = 1'b1;
      tick();

      // Setup then a 3-word block, brdy every second cycle
      kick(8'h08, 8'h03, 1'b0);
      tick(); start_r = 1'b0;
      check("wrcr_i", 32'(act[0].i), 32'h0);
      check("wrcr_dout", 32'(act[0].dout), 32'h00);
      tick();
      check("ldar_i", 32'(act[0].i), 32'h5);
      check("ldar_dout", 32'(act[0].dout), 32'h08);
      tick();
      check("ldwc_i", 32'(act[0].i), 32'h6);
      check("ldwc_dout", 32'(act[0].dout), 32'h03);
      tick();
      check("arb_breq", 32'(act[0].breq), 32'h1);
      check("arb_oe", 32'(act[0].dout_oe), 32'h0);
      np = 0;
      prev_ar = env_ar[0];
      for (int c = 0; c < 40 && (act[0].busy || act[1].busy); c++) begin
         brdy_r = ~brdy_r;
         tick();
         if (env_ar[0] != prev_ar) begin
            if (np < 3) check($sformatf("addr_after_xfer%0d", np), 32'(env_ar[0]), 32'(exp_ar[np]));
            np++;
            prev_ar = env_ar[0];
         end
      end
      check("burst_fin_busy", 32'(act[0].busy), 32'h0);
      check("burst_fin_irq", 32'(act[0].irq), 32'h1);
      check("burst_fin_breq", 32'(act[0].breq), 32'h0);
      check("burst_aci_pulses", 32'(aci_cnt[0]), 32'd3);
      check("burst_breq_rises", 32'(rise_cnt[0]), 32'd1);
      check("single_aci_pulses", 32'(aci_cnt[1]), 32'd3);
      check("single_breq_rises", 32'(rise_cnt[1]), 32'd3);
      check("single_fin_addr", 32'(env_ar[1]), 32'h0B);

      // Timeout: brdy never comes
      kick(8'h08, 8'h03, 1'b0);
      tick(); start_r = 1'b0;
      check("to_irq_cleared", 32'(act[0].irq), 32'h0);
      for (int c = 2; c <= 8; c++) tick();
      check("to_xfer4_dack", 32'(act[0].dack), 32'h1);
      check("to_xfer4_err", 32'(act[0].err), 32'h0);
      tick();
      check("to_err", 32'(act[0].err), 32'h1);
      check("to_irq", 32'(act[0].irq), 32'h1);
      check("to_busy", 32'(act[0].busy), 32'h0);
      check("to_err_lane1", 32'(act[1].err), 32'h1);
      check("to_no_pulse", 32'(aci_cnt[0] + aci_cnt[1]), 32'd0);
      check("to_addr", 32'(env_ar[0]), 32'h08);

      // Address wrap 0xFF -> 0x00
      kick(8'hFE, 8'h03, 1'b1);
      tick(); start_r = 1'b0;
      saw_ff = 1'b0;
      saw_00 = 1'b0;
      for (int c = 0; c < 30 && (act[0].busy || act[1].busy); c++) begin
         tick();
         if (env_ar[0] == 8'hFF && !saw_ff) begin
            check("wrap_before", 32'(act[0].wrap), 32'h0);
            saw_ff = 1'b1;
         end
         if (env_ar[0] == 8'h00 && !saw_00) begin
            check("wrap_set", 32'(act[0].wrap), 32'h1);
            saw_00 = 1'b1;
         end
      end
      check("wrap_seen", 32'({saw_ff, saw_00}), 32'h3);
      check("wrap_fin_addr", 32'(env_ar[0]), 32'h01);
      check("wrap_lane1", 32'(act[1].wrap), 32'h1);

      // Abort while memory is ready
      kick(8'h08, 8'h03, 1'b0);
      tick(); start_r = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      check("ab_in_xfer", 32'(act[0].dack), 32'h1);
      brdy_r = 1'b1;
      abort_r = 1'b1;
      #1;
      check("ab_no_pulse", 32'(act[0].aci_), 32'h1);
      tick();
      abort_r = 1'b0;
      brdy_r = 1'b0;
      check("ab_busy", 32'(act[0].busy), 32'h0);
      check("ab_breq", 32'(act[0].breq), 32'h0);
      check("ab_irq", 32'(act[0].irq), 32'h0);
      check("ab_addr", 32'(env_ar[0]), 32'h08);

      // Random traffic against the reference
      for (int c = 0; c < 3000; c++) begin
         start_r = ($urandom_range(0, 7) == 0);
         abort_r = ($urandom_range(0, 63) == 0);
         dreq_r  = ($urandom_range(0, 3) != 0);
         bgnt_r  = 1'($urandom_range(0, 1));
         brdy_r  = ($urandom_range(0, 2) != 0);
         mode_r  = 3'($urandom);
         addr_r  = 8'($urandom);
         count_r = 8'($urandom_range(1, 5));
         tick();
      end
      start_r = 1'b0;
      abort_r = 1'b1;
      tick();
      abort_r = 1'b0;

      // Asynchronous reset in the middle of a transfer
      kick(8'h08, 8'h03, 1'b0);
      tick(); start_r = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      check("mr_in_xfer", 32'(act[0].dack), 32'h1);
      #2;
      mr_n = 1'b0;
      #1;
      check("mr_async_lane0", 32'(act[0]), 32'(RST_V));
      check("mr_async_lane1", 32'(act[1]), 32'(RST_V));
      for (int k = 0; k < 2; k++) model_reset(k);
      tick();
      tick();
      mr_n = 1'b1;
      for (int c = 0; c < 3; c++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
